dpram_port_arbiter: RTL and testbench

//   Shares one dpram macro (32b x 1024, separate write and read ports, 1-cycle read latency) between NREQ requesters.

---
 rtl/dpram_port_arbiter.sv | 117 +++++++++++
 tb/tb_dpram_port_arbiter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dpram_port_arbiter.sv
// rtl/dpram_port_arbiter.sv - dual round-robin arbiter sharing one dpram between NREQ requesters
// Write and read ports arbitrate independently; same-address read is held back a cycle behind the write.
module dpram_port_arbiter #(
    parameter int NREQ = 2,
    parameter int AW   = 10,
    parameter int DW   = 32,
    parameter int CNTW = 16
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [NREQ-1:0]    req_valid_i,
    input  logic [NREQ-1:0]    req_we_i,
    input  logic [NREQ*AW-1:0] req_addr_i,
    input  logic [NREQ*DW-1:0] req_wdata_i,
    output logic [NREQ-1:0]    req_ready_o,
    output logic [NREQ-1:0]    rsp_valid_o,
    output logic [DW-1:0]      rsp_rdata_o,
    output logic               mem_wen_o,
    output logic [AW-1:0]      mem_waddr_o,
    output logic [DW-1:0]      mem_d_in_o,
    output logic               mem_ren_o,
    output logic [AW-1:0]      mem_raddr_o,
    input  logic [DW-1:0]      mem_d_out_i,
    output logic [CNTW-1:0]    conflict_cnt_o
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [PW-1:0] PTR_RST = PW'(NREQ - 1);

    logic [PW-1:0]   wptr_q, wptr_d;
    logic [PW-1:0]   rptr_q, rptr_d;
    logic [PW-1:0]   rsp_owner_q, rsp_owner_d;
    logic            rsp_vld_q, rsp_vld_d;
    logic [CNTW-1:0] cnt_q, cnt_d;

    logic [NREQ-1:0] w_cand, r_cand;
    logic [PW:0]     w_sel, r_sel;
    logic            w_found, r_found;
    logic [PW-1:0]   w_idx, r_idx;
    logic [AW-1:0]   w_addr, r_addr;
    logic [DW-1:0]   w_data;
    logic            collision, w_gnt, r_gnt;

    // Scan from ptr+1 downward-overwriting so the nearest candidate after ptr wins.
    function automatic logic [PW:0] rr_pick(input logic [NREQ-1:0] cand,
                                            input logic [PW-1:0]   ptr);
        logic [PW:0] res;
        int          j;
        res = '0;
        for (int k = NREQ; k >= 1; k--) begin
            j = (int'(ptr) + k) % NREQ;
            if (cand[j]) res = {1'b1, PW'(j)};
        end
        return res;
    endfunction

    always_comb begin
        w_cand  = req_valid_i & req_we_i;
        r_cand  = req_valid_i & ~req_we_i;
        w_sel   = rr_pick(w_cand, wptr_q);
        r_sel   = rr_pick(r_cand, rptr_q);
        w_found = w_sel[PW];
        r_found = r_sel[PW];
        w_idx   = w_sel[PW-1:0];
        r_idx   = r_sel[PW-1:0];
        w_addr  = req_addr_i[int'(w_idx)*AW +: AW];
        w_data  = req_wdata_i[int'(w_idx)*DW +: DW];
        r_addr  = req_addr_i[int'(r_idx)*AW +: AW];

        // The write always wins a same-address collision, so the retried read sees the new data.
        collision = w_found && r_found && (r_addr == w_addr);
        w_gnt     = w_found && rst_ni;
        r_gnt     = r_found && !collision && rst_ni;

        for (int i = 0; i < NREQ; i++) begin
            req_ready_o[i] = (w_gnt && (w_idx == PW'(i))) || (r_gnt && (r_idx == PW'(i)));
        end

        mem_wen_o   = w_gnt;
        mem_waddr_o = w_gnt ? w_addr : '0;
        mem_d_in_o  = w_gnt ? w_data : '0;
        mem_ren_o   = r_gnt;
        mem_raddr_o = r_gnt ? r_addr : '0;

        wptr_d      = w_gnt ? w_idx : wptr_q;
        rptr_d      = r_gnt ? r_idx : rptr_q;
        rsp_vld_d   = r_gnt;
        rsp_owner_d = r_gnt ? r_idx : rsp_owner_q;
        cnt_d       = cnt_q;
        if (collision && (cnt_q != {CNTW{1'b1}})) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q      <= PTR_RST;
            rptr_q      <= PTR_RST;
            rsp_owner_q <= '0;
            rsp_vld_q   <= 1'b0;
            cnt_q       <= '0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            rsp_owner_q <= rsp_owner_d;
            rsp_vld_q   <= rsp_vld_d;
            cnt_q       <= cnt_d;
        end
    end

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            rsp_valid_o[i] = rsp_vld_q && (rsp_owner_q == PW'(i));
        end
        rsp_rdata_o    = rsp_vld_q ? mem_d_out_i : '0;
        conflict_cnt_o = cnt_q;
    end

endmodule

// File: tb/tb_dpram_port_arbiter.sv
// tb/tb_dpram_port_arbiter.sv - directed bench for dpram_port_arbiter with a behavioural dpram
module tb_dpram_port_arbiter;

    localparam int NREQ = 2;
    localparam int AW   = 10;
    localparam int DW   = 32;
    localparam int CNTW = 4;

    logic               clk;
    logic               rst_n;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_we;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_wdata;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ-1:0]    rsp_valid;
    logic [DW-1:0]      rsp_rdata;
    logic               mem_wen;
    logic [AW-1:0]      mem_waddr;
    logic [DW-1:0]      mem_d_in;
    logic               mem_ren;
    logic [AW-1:0]      mem_raddr;
    logic [DW-1:0]      mem_d_out;
    logic [CNTW-1:0]    conflict_cnt;

    int total;
    int passed;

    bit [DW-1:0] mem [1024];

    dpram_port_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .CNTW(CNTW)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .req_valid_i    (req_valid),
        .req_we_i       (req_we),
        .req_addr_i     (req_addr),
        .req_wdata_i    (req_wdata),
        .req_ready_o    (req_ready),
        .rsp_valid_o    (rsp_valid),
        .rsp_rdata_o    (rsp_rdata),
        .mem_wen_o      (mem_wen),
        .mem_waddr_o    (mem_waddr),
        .mem_d_in_o     (mem_d_in),
        .mem_ren_o      (mem_ren),
        .mem_raddr_o    (mem_raddr),
        .mem_d_out_i    (mem_d_out),
        .conflict_cnt_o (conflict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_wen) mem[mem_waddr] <= mem_d_in;
        if (mem_ren) mem_d_out <= mem[mem_raddr];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
    endtask

    task automatic drive(input int i, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[i]          = 1'b1;
        req_we[i]             = we;
        req_addr[i*AW +: AW]  = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    task automatic apply_reset();
        idle();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        idle();
        mem_d_out = 32'hCAFE_F00D;
        rst_n = 1'b0;
        drive(0, 1'b1, 10'h001, 32'h1);
        drive(1, 1'b0, 10'h002, 32'h0);
        step();
        #2;
        total++;
        if ({req_ready, mem_wen, mem_ren} !== 4'b0)
            $display("FAIL reset_gate ready=%b wen=%b ren=%b required 0", req_ready, mem_wen, mem_ren);
        else passed++;
        total++;
        if ({rsp_valid, rsp_rdata, conflict_cnt} !== '0)
            $display("FAIL reset_outs rsp_valid=%b rdata=%h cnt=%h required 0", rsp_valid, rsp_rdata, conflict_cnt);
        else passed++;
        apply_reset();
    endtask

    task automatic test_write_read();
        apply_reset();
        drive(0, 1'b1, 10'h005, 32'hDEAD_BEEF);
        #2;
        total++;
        if ({req_ready, mem_wen, mem_waddr, mem_d_in} !== {2'b01, 1'b1, 10'h005, 32'hDEAD_BEEF})
            $display("FAIL wr_grant ready=%b wen=%b waddr=%h din=%h required 01/1/005/deadbeef", req_ready, mem_wen, mem_waddr, mem_d_in);
        else passed++;
        step();
        idle();
        drive(0, 1'b0, 10'h005, 32'h0);
        #2;
        total++;
        if ({req_ready, mem_wen, mem_ren, mem_raddr, rsp_valid} !== {2'b01, 1'b0, 1'b1, 10'h005, 2'b00})
            $display("FAIL rd_grant ready=%b wen=%b ren=%b raddr=%h rsp=%b required 01/0/1/005/00", req_ready, mem_wen, mem_ren, mem_raddr, rsp_valid);
        else passed++;
        step();
        idle();
        #2;
        total++;
        if ({rsp_valid, rsp_rdata} !== {2'b01, 32'hDEAD_BEEF})
            $display("FAIL rd_rsp rsp=%b rdata=%h required 01/deadbeef", rsp_valid, rsp_rdata);
        else passed++;
        step();
        #2;
        total++;
        if ({rsp_valid, rsp_rdata} !== '0)
            $display("FAIL rsp_idle rsp=%b rdata=%h required 00/0", rsp_valid, rsp_rdata);
        else passed++;
    endtask

    task automatic test_write_contention();
        logic [1:0]    exp_rdy [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
        logic [AW-1:0] exp_adr [4] = '{10'h001, 10'h002, 10'h001, 10'h002};
        apply_reset();
        drive(0, 1'b1, 10'h001, 32'h1111_1111);
        drive(1, 1'b1, 10'h002, 32'h2222_2222);
        for (int c = 0; c < 4; c++) begin
            #2;
            total++;
            if ({req_ready, mem_waddr} !== {exp_rdy[c], exp_adr[c]})
                $display("FAIL wr_rr cycle %0d ready=%b waddr=%h required %b/%h", c, req_ready, mem_waddr, exp_rdy[c], exp_adr[c]);
            else passed++;
            step();
        end
        idle();
    endtask

    task automatic test_parallel_ports();
        apply_reset();
        drive(0, 1'b1, 10'h010, 32'hA5A5_A5A5);
        drive(1, 1'b0, 10'h020, 32'h0);
        #2;
        total++;
        if ({req_ready, mem_wen, mem_ren, mem_waddr, mem_raddr} !== {2'b11, 1'b1, 1'b1, 10'h010, 10'h020})
            $display("FAIL par_ports ready=%b wen=%b ren=%b waddr=%h raddr=%h required 11/1/1/010/020", req_ready, mem_wen, mem_ren, mem_waddr, mem_raddr);
        else passed++;
        step();
        idle();
        #2;
        total++;
        if ({conflict_cnt, rsp_valid, rsp_rdata} !== {4'h0, 2'b10, 32'h0})
            $display("FAIL par_rsp cnt=%h rsp=%b rdata=%h required 0/10/0", conflict_cnt, rsp_valid, rsp_rdata);
        else passed++;
    endtask

    task automatic test_back_to_back();
        logic [1:0]  exp_rdy [5] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b00};
        logic [1:0]  exp_rsp [5] = '{2'b00, 2'b01, 2'b10, 2'b01, 2'b10};
        logic [31:0] exp_dat [5] = '{32'h0, 32'hA5A5_A5A5, 32'hDEAD_BEEF, 32'hA5A5_A5A5, 32'hDEAD_BEEF};
        apply_reset();
        drive(0, 1'b0, 10'h010, 32'h0);
        drive(1, 1'b0, 10'h005, 32'h0);
        for (int c = 0; c < 5; c++) begin
            if (c == 4) idle();
            #2;
            total++;
            if ({req_ready, rsp_valid, rsp_rdata} !== {exp_rdy[c], exp_rsp[c], exp_dat[c]})
                $display("FAIL b2b_rd cycle %0d ready=%b rsp=%b rdata=%h required %b/%b/%h", c, req_ready, rsp_valid, rsp_rdata, exp_rdy[c], exp_rsp[c], exp_dat[c]);
            else passed++;
            step();
        end
    endtask

    task automatic test_collision();
        apply_reset();
        drive(0, 1'b1, 10'h3FF, 32'h1234_5678);
        drive(1, 1'b0, 10'h3FF, 32'h0);
        #2;
        total++;
        if ({req_ready, mem_wen, mem_ren, mem_raddr} !== {2'b01, 1'b1, 1'b0, 10'h000})
            $display("FAIL coll_block ready=%b wen=%b ren=%b raddr=%h required 01/1/0/000", req_ready, mem_wen, mem_ren, mem_raddr);
        else passed++;
        step();
        req_valid[0] = 1'b0;
        #2;
        total++;
        if ({conflict_cnt, req_ready, mem_ren, mem_raddr} !== {4'h1, 2'b10, 1'b1, 10'h3FF})
            $display("FAIL coll_retry cnt=%h ready=%b ren=%b raddr=%h required 1/10/1/3ff", conflict_cnt, req_ready, mem_ren, mem_raddr);
        else passed++;
        step();
        idle();
        #2;
        total++;
        if ({rsp_valid, rsp_rdata, conflict_cnt} !== {2'b10, 32'h1234_5678, 4'h1})
            $display("FAIL coll_rsp rsp=%b rdata=%h cnt=%h required 10/12345678/1", rsp_valid, rsp_rdata, conflict_cnt);
        else passed++;
    endtask

    task automatic test_reset_mid_read();
        apply_reset();
        drive(0, 1'b0, 10'h005, 32'h0);
        #2;
        total++;
        if (req_ready !== 2'b01)
            $display("FAIL mid_rd_grant ready=%b required 01", req_ready);
        else passed++;
        rst_n = 1'b0;
        drive(1, 1'b1, 10'h006, 32'h9);
        #1;
        total++;
        if ({req_ready, mem_wen, mem_ren} !== 4'b0)
            $display("FAIL mid_rst_gate ready=%b wen=%b ren=%b required 0", req_ready, mem_wen, mem_ren);
        else passed++;
        step();
        #2;
        total++;
        if ({rsp_valid, rsp_rdata} !== '0)
            $display("FAIL mid_rst_rsp rsp=%b rdata=%h required 00/0", rsp_valid, rsp_rdata);
        else passed++;
        step();
        rst_n = 1'b1;
        idle();
        drive(0, 1'b0, 10'h005, 32'h0);
        drive(1, 1'b0, 10'h010, 32'h0);
        #2;
        total++;
        if ({req_ready, rsp_valid} !== {2'b01, 2'b00})
            $display("FAIL mid_rst_prio ready=%b rsp=%b required 01/00", req_ready, rsp_valid);
        else passed++;
        step();
        idle();
    endtask

    task automatic test_saturation();
        apply_reset();
        drive(0, 1'b1, 10'h007, 32'h7);
        drive(1, 1'b0, 10'h007, 32'h0);
        for (int c = 1; c <= 19; c++) begin
            step();
            if (c == 14) begin
                total++;
                if (conflict_cnt !== 4'hE)
                    $display("FAIL sat_count cnt=%h required e", conflict_cnt);
                else passed++;
            end
        end
        #2;
        total++;
        if ({conflict_cnt, req_ready} !== {4'hF, 2'b01})
            $display("FAIL sat_hold cnt=%h ready=%b required f/01", conflict_cnt, req_ready);
        else passed++;
        idle();
        step();
    endtask

    initial begin
        total  = 0;
        passed = 0;
        rst_n  = 1'b0;
        idle();
        test_reset();
        test_write_read();
        test_write_contention();
        test_parallel_ports();
        test_back_to_back();
        test_collision();
        test_reset_mid_read();
        test_saturation();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
